// File: rtl/enable_rst.sv
// Restart-request conditioner: synchronizes and debounces a raw restart line and
// emits one fixed-length registered restart pulse per debounced rising press.
module enable_rst #(
  parameter int unsigned DEBOUNCE_CYCLES = 1,
  parameter int unsigned PULSE_CYCLES    = 1
) (
  input  logic CLK,
  input  logic RST,
  input  logic IN,
  output logic restart
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0]    PULSE_MAX = 8'(PULSE_CYCLES - 1);

  typedef enum logic {IDLE, PULSE} state_t;

  logic          s1, s2;
  logic          stable;
  logic [CW-1:0] cnt;
  logic          accept;
  logic          rise;

  state_t        state, state_d;
  logic [7:0]    pcnt, pcnt_d;
  logic          restart_d;

  // Two-flop synchronizer; only s2 is allowed to reach the rest of the logic.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= IN;
      s2 <= s1;
    end
  end

  // A change is accepted on the edge where the count has reached its limit,
  // so the pulse FSM can react on that very same edge.
  assign accept = (s2 != stable) && (cnt == CNT_MAX);
  assign rise   = accept && s2;

  always_ff @(posedge CLK) begin
    if (RST) begin
      stable <= 1'b0;
      cnt    <= '0;
    end else if (s2 == stable) begin
      cnt    <= '0;
    end else if (accept) begin
      stable <= s2;
      cnt    <= '0;
    end else begin
      cnt    <= cnt + CW'(1);
    end
  end

  always_comb begin
    state_d   = state;
    pcnt_d    = pcnt;
    restart_d = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          state_d   = PULSE;
          pcnt_d    = PULSE_MAX;
          restart_d = 1'b1;
        end
      end
      PULSE: begin
        // Presses arriving here are dropped: no re-trigger, no extension.
        if (pcnt == 8'd0) begin
          state_d = IDLE;
        end else begin
          pcnt_d    = pcnt - 8'd1;
          restart_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      pcnt    <= 8'd0;
      restart <= 1'b0;
    end else begin
      state   <= state_d;
      pcnt    <= pcnt_d;
      restart <= restart_d;
    end
  end

endmodule

// File: tb/tb_enable_rst.sv
// Scoreboard bench for enable_rst: four instances with different debounce/pulse
// settings; stimulus queues expected pulses, a monitor checks start and length.
module tb_enable_rst;

  localparam int N = 4;

  logic         clk;
  logic [N-1:0] rst_v;
  logic [N-1:0] in_v;
  logic [N-1:0] restart_v;
  int           cyc;
  int           n_chk;
  int           n_fail;

  typedef struct {
    int start;
    int len;
  } exp_t;

  exp_t exp_q[N][$];

  // inst0: D=1 P=1, inst1: D=4 P=1, inst2: D=1 P=3, inst3: D=2 P=4
  for (genvar g = 0; g < N; g++) begin : g_dut
    enable_rst #(
      .DEBOUNCE_CYCLES(g == 1 ? 4 : (g == 3 ? 2 : 1)),
      .PULSE_CYCLES   (g == 2 ? 3 : (g == 3 ? 4 : 1))
    ) dut (
      .CLK    (clk),
      .RST    (rst_v[g]),
      .IN     (in_v[g]),
      .restart(restart_v[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int k, input int start, input int len);
    exp_t e;
    e.start = start;
    e.len   = len;
    exp_q[k].push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: a rising restart pops an expectation and checks its start cycle;
  // the falling edge checks the measured length.
  logic [N-1:0] prev;
  bit           have[N];
  exp_t         cur[N];
  int           plen[N];

  initial begin
    prev = '0;
    for (int k = 0; k < N; k++) begin
      have[k] = 1'b0;
      plen[k] = 0;
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (restart_v[k] && !prev[k]) begin
        n_chk++;
        plen[k] = 1;
        if (exp_q[k].size() == 0) begin
          n_fail++;
          have[k] = 1'b0;
          $display("FAIL pulse_unexpected inst%0d: pulse at cycle %0d, required none", k, cyc);
        end else begin
          cur[k]  = exp_q[k].pop_front();
          have[k] = 1'b1;
          if (cyc != cur[k].start) begin
            n_fail++;
            $display("FAIL pulse_start inst%0d: got cycle %0d, required %0d", k, cyc, cur[k].start);
          end
        end
      end else if (restart_v[k]) begin
        plen[k]++;
      end else if (prev[k] && have[k]) begin
        n_chk++;
        have[k] = 1'b0;
        if (plen[k] != cur[k].len) begin
          n_fail++;
          $display("FAIL pulse_len inst%0d: got %0d cycles, required %0d", k, plen[k], cur[k].len);
        end
      end
      prev[k] = restart_v[k];
    end
  end

  int s;

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_v  = '1;
    in_v   = '0;
    tick(2);
    for (int k = 0; k < N; k++) begin
      n_chk++;
      if (restart_v[k] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_restart inst%0d: got %b, required 0", k, restart_v[k]);
      end
    end
    rst_v = '0;
    tick(3);

    // inst0: short press, then a long hold giving one pulse, then a re-press
    in_v[0] = 1'b1; push(0, cyc + 3, 1);
    tick(2); in_v[0] = 1'b0;
    tick(6);
    in_v[0] = 1'b1; push(0, cyc + 3, 1);
    tick(20); in_v[0] = 1'b0;
    tick(6);
    in_v[0] = 1'b1; push(0, cyc + 3, 1);
    tick(3); in_v[0] = 1'b0;
    tick(6);

    // inst1: 3-cycle glitches never pass a 4-cycle debounce; a 4-cycle press does
    repeat (3) begin
      in_v[1] = 1'b1; tick(3);
      in_v[1] = 1'b0; tick(1);
    end
    tick(6);
    in_v[1] = 1'b1; push(1, cyc + 6, 1);
    tick(4); in_v[1] = 1'b0;
    tick(10);

    // inst2: a debounced release and re-press inside the pulse is ignored
    in_v[2] = 1'b1; push(2, cyc + 3, 3);
    tick(2); in_v[2] = 1'b0;
    tick(1); in_v[2] = 1'b1;
    tick(10); in_v[2] = 1'b0;
    tick(5);
    in_v[2] = 1'b1; push(2, cyc + 3, 3);
    tick(3); in_v[2] = 1'b0;
    tick(8);

    // inst3: reset on the 2nd pulse cycle truncates; held IN re-triggers after
    in_v[3] = 1'b1; s = cyc + 4; push(3, s, 2);
    tick(5);
    rst_v[3] = 1'b1;
    tick(1);
    rst_v[3] = 1'b0; push(3, cyc + 4, 4);
    tick(12); in_v[3] = 1'b0;
    tick(8);

    for (int k = 0; k < N; k++) begin
      n_chk++;
      if (exp_q[k].size() != 0) begin
        n_fail++;
        $display("FAIL pulse_missing inst%0d: %0d expected pulses not seen, required 0", k, exp_q[k].size());
      end
      n_chk++;
      if (restart_v[k] !== 1'b0) begin
        n_fail++;
        $display("FAIL final_idle inst%0d: restart=%b, required 0", k, restart_v[k]);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
